display_scan_ctrl: RTL

Time-multiplexed scan controller that shares one BCD-to-7-segment decoder across NUM_DIGITS common-anode digits. It presents one digit's BCD code to the decoder at a time and drives the matching active-low digit enable, with an optional ghost-blanking gap between digits. New display data is double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new values. Optional leading-zero suppression is supported. The downstream decoder turns all segments off for codes 10–15, so this block uses 4'hF as its blank code.

---
 rtl/display_scan_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller that shares one BCD-to-7-segment decoder
//   across NUM_DIGITS common-anode digits. The block drives one digit at a time
//   for PRESCALE cycles. An optional gap of GHOST_CYCLES blank cycles can be
//   inserted between digits. Display data is double-buffered and is applied only
//   at frame boundaries. Leading-zero suppression is optional. 4'hF is the blank
//   code; the decoder turns all segments off for codes 10-15.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : scan enable; low keeps the display dark
//   load       : one-cycle strobe; captures digits_in into the shadow register
//   digits_in  : packed BCD, digit i at [4i+3:4i]; digit 0 is least significant
//   lz_en      : leading-zero suppression enable
//   bcd_out    : registered code to the 7-segment decoder
//   anode_n    : registered active-low digit enables; at most one bit is low
//   frame_done : one-cycle pulse on the first cycle of the next frame

module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int GHOST_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lz_en,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
  localparam int PRE_W = (PRESCALE     > 1) ? $clog2(PRESCALE)     : 1;
  localparam int GH_W  = (GHOST_CYCLES > 1) ? $clog2(GHOST_CYCLES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [GH_W-1:0]  GH_LAST  = GH_W'((GHOST_CYCLES > 0) ? GHOST_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GHOST = 2'd2;

  localparam logic [3:0] BLANK = 4'hF;

  logic [1:0]              r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [PRE_W-1:0]        r_pre;
  logic [GH_W-1:0]         r_ghost;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_pending;
  logic [3:0]              r_bcd;
  logic [NUM_DIGITS-1:0]   r_anode_n;
  logic                    r_frame_done;

  logic [1:0]              w_state_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [PRE_W-1:0]        w_pre_nxt;
  logic [GH_W-1:0]         w_ghost_nxt;
  logic                    w_advance;
  logic                    w_apply;
  logic                    w_frame_nxt;
  logic [4*NUM_DIGITS-1:0] w_active_nxt;
  logic [4*NUM_DIGITS-1:0] w_shadow_nxt;
  logic                    w_pending_nxt;
  logic [3:0]              w_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_blank;
  logic                    w_zero_run;
  logic [3:0]              w_bcd_nxt;
  logic [NUM_DIGITS-1:0]   w_anode_nxt;

  assign bcd_out    = r_bcd;
  assign anode_n    = r_anode_n;
  assign frame_done = r_frame_done;

  // Scan sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pre_nxt   = r_pre;
    w_ghost_nxt = r_ghost;
    w_advance   = 1'b0;
    w_apply     = 1'b0;
    w_frame_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_DRIVE;
          w_idx_nxt   = '0;
          w_pre_nxt   = '0;
          w_apply     = 1'b1;
        end
      end
      S_DRIVE: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_pre_nxt   = '0;
          w_ghost_nxt = '0;
        end else if (r_pre == PRE_LAST) begin
          w_pre_nxt = '0;
          if (GHOST_CYCLES > 0) begin
            w_state_nxt = S_GHOST;
            w_ghost_nxt = '0;
          end else begin
            w_advance = 1'b1;
          end
        end else begin
          w_pre_nxt = r_pre + 1'b1;
        end
      end
      S_GHOST: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_pre_nxt   = '0;
          w_ghost_nxt = '0;
        end else if (r_ghost == GH_LAST) begin
          w_ghost_nxt = '0;
          w_advance   = 1'b1;
        end else begin
          w_ghost_nxt = r_ghost + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_pre_nxt   = '0;
        w_ghost_nxt = '0;
      end
    endcase

    // Wrapping past the last digit is the frame boundary.
    if (w_advance) begin
      w_state_nxt = S_DRIVE;
      if (r_idx == IDX_LAST) begin
        w_idx_nxt   = '0;
        w_frame_nxt = 1'b1;
        w_apply     = 1'b1;
      end else begin
        w_idx_nxt = r_idx + 1'b1;
      end
    end
  end

  // Double buffering. A load that coincides with an apply point bypasses the
  // shadow, so the new frame shows the new value right away.
  always_comb begin
    w_active_nxt  = r_active;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    if (w_apply) begin
      if (load) begin
        w_active_nxt  = digits_in;
        w_shadow_nxt  = digits_in;
        w_pending_nxt = 1'b0;
      end else if (r_pending) begin
        w_active_nxt  = r_shadow;
        w_pending_nxt = 1'b0;
      end
    end else if (load) begin
      w_shadow_nxt  = digits_in;
      w_pending_nxt = 1'b1;
    end
  end

  // Digit values and leading-zero blanking. The scan runs from the most
  // significant digit downwards. A digit is blanked only while every digit
  // from that position up to the top is zero. Digit 0 is never blanked.
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_digit[k] = w_active_nxt[4*k +: 4];
    end
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_zero_run = w_zero_run & (w_digit[NUM_DIGITS-1-k] == 4'h0);
      w_blank[NUM_DIGITS-1-k] = lz_en & w_zero_run & ((NUM_DIGITS-1-k) != 0);
    end
  end

  // Output values for the next cycle. They are dark unless the next state is DRIVE.
  always_comb begin
    w_bcd_nxt   = BLANK;
    w_anode_nxt = '1;
    if (w_state_nxt == S_DRIVE) begin
      w_bcd_nxt              = w_blank[w_idx_nxt] ? BLANK : w_digit[w_idx_nxt];
      w_anode_nxt[w_idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_pre        <= '0;
      r_ghost      <= '0;
      r_active     <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_bcd        <= BLANK;
      r_anode_n    <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_pre        <= w_pre_nxt;
      r_ghost      <= w_ghost_nxt;
      r_active     <= w_active_nxt;
      r_shadow     <= w_shadow_nxt;
      r_pending    <= w_pending_nxt;
      r_bcd        <= w_bcd_nxt;
      r_anode_n    <= w_anode_nxt;
      r_frame_done <= w_frame_nxt;
    end
  end

endmodule
